// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - shared player state enum, widths and damage helper for combat_manager
package combat_pkg;

    localparam int DAMAGE_W = 10;
    localparam int STOCK_W  = 3;
    localparam int CNT_W    = 12;
    localparam int unsigned DAMAGE_MAX = (1 << DAMAGE_W) - 1;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_HITSTUN = 2'd1,
        ST_KO      = 2'd2,
        ST_OUT     = 2'd3
    } player_state_t;

    function automatic logic [DAMAGE_W-1:0] sat_add(input logic [DAMAGE_W-1:0] d,
                                                      input int unsigned inc);
        int unsigned s;
        s = 32'(d) + inc;
        return (s > DAMAGE_MAX) ? DAMAGE_W'(DAMAGE_MAX) : DAMAGE_W'(s);
    endfunction

endpackage

// File: rtl/player_life_fsm.sv
// rtl/player_life_fsm.sv - per-player ACTIVE/HITSTUN/KO/OUT life cycle (COMBAT_STUN_SCALE_EN scales hitstun)
module player_life_fsm
    import combat_pkg::*;
#(
    parameter int DAMAGE_PER_HIT = 12,
    parameter int KO_THRESHOLD   = 100,
    parameter int HITSTUN_FRAMES = 20,
    parameter int STOCKS         = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_tick,
    input  logic                hit,
    output player_state_t       state,
    output logic [DAMAGE_W-1:0] damage,
    output logic [STOCK_W-1:0]  stocks_left,
    output logic                respawn_pulse
);

    player_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DAMAGE_W-1:0] damage_q, damage_d;
    logic [STOCK_W-1:0]  stocks_q, stocks_d;
    logic                pulse_q, pulse_d;
    logic [DAMAGE_W-1:0] new_dmg;
    logic [CNT_W-1:0]    stun_load;

    assign new_dmg = sat_add(damage_q, DAMAGE_PER_HIT);

`ifdef COMBAT_STUN_SCALE_EN
    assign stun_load = CNT_W'(HITSTUN_FRAMES) + CNT_W'(new_dmg >> 4);
`else
    assign stun_load = CNT_W'(HITSTUN_FRAMES);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ACTIVE;
            cnt_q    <= '0;
            damage_q <= '0;
            stocks_q <= STOCK_W'(STOCKS);
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            damage_q <= damage_d;
            stocks_q <= stocks_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        damage_d = damage_q;
        stocks_d = stocks_q;
        pulse_d  = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (hit) begin
                    damage_d = new_dmg;
                    if (int'(new_dmg) >= KO_THRESHOLD) begin
                        stocks_d = stocks_q - STOCK_W'(1);
                        if (stocks_q <= STOCK_W'(1)) begin
                            state_d = ST_OUT;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_KO;
                            cnt_d   = CNT_W'(RESPAWN_FRAMES);
                        end
                    end else begin
                        state_d = ST_HITSTUN;
                        cnt_d   = stun_load;
                    end
                end
            end
            ST_HITSTUN: begin
                if (frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_KO: begin
                // Respawn clears damage and announces itself with a single-cycle pulse
                if (frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d  = ST_ACTIVE;
                        cnt_d    = '0;
                        damage_d = '0;
                        pulse_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign state         = state_q;
    assign damage        = damage_q;
    assign stocks_left   = stocks_q;
    assign respawn_pulse = pulse_q;

endmodule

// File: rtl/combat_manager.sv
// rtl/combat_manager.sv - hit resolution and game-over tracking across players (COMBAT_STUN_SCALE_EN in player_life_fsm)
module combat_manager
    import combat_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int DAMAGE_PER_HIT = 12,
    parameter int KO_THRESHOLD   = 100,
    parameter int HITSTUN_FRAMES = 20,
    parameter int STOCKS         = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            frame_tick,
    input  logic [NUM_PLAYERS-1:0]          attack_btn,
    input  logic [NUM_PLAYERS*NUM_PLAYERS-1:0] overlap,
    output logic [NUM_PLAYERS*DAMAGE_W-1:0] damage,
    output logic [NUM_PLAYERS-1:0]          hit_stun_active,
    output logic [NUM_PLAYERS-1:0]          alive,
    output logic [NUM_PLAYERS*STOCK_W-1:0]  stocks_left,
    output logic [NUM_PLAYERS-1:0]          respawn_pulse,
    output logic                            game_over,
    output logic [1:0]                      winner,
    output logic                            winner_valid
);

    player_state_t          st [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] prev_btn;
    logic                   armed;
    logic [NUM_PLAYERS-1:0] atk_edge;
    logic [NUM_PLAYERS-1:0] hit;
    logic [2:0]             live_cnt;
    logic [1:0]             win_idx;
    logic                   win_found;
    logic                   over_d;

    // armed stays low for the first cycle out of reset so a held button cannot look like a fresh press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_btn <= '0;
            armed    <= 1'b0;
        end else begin
            prev_btn <= attack_btn;
            armed    <= 1'b1;
        end
    end

    assign atk_edge = attack_btn & ~prev_btn & {NUM_PLAYERS{armed}};

    // OR-reduction per victim: several attackers landing together is still one hit
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (i != j && atk_edge[i] && st[i] == ST_ACTIVE &&
                    overlap[i*NUM_PLAYERS+j] && st[j] == ST_ACTIVE) begin
                    hit[j] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        player_life_fsm #(
            .DAMAGE_PER_HIT (DAMAGE_PER_HIT),
            .KO_THRESHOLD   (KO_THRESHOLD),
            .HITSTUN_FRAMES (HITSTUN_FRAMES),
            .STOCKS         (STOCKS),
            .RESPAWN_FRAMES (RESPAWN_FRAMES)
        ) u_player (
            .clk           (clk),
            .reset_n       (reset_n),
            .frame_tick    (frame_tick),
            .hit           (hit[g]),
            .state         (st[g]),
            .damage        (damage[g*DAMAGE_W +: DAMAGE_W]),
            .stocks_left   (stocks_left[g*STOCK_W +: STOCK_W]),
            .respawn_pulse (respawn_pulse[g])
        );
        assign hit_stun_active[g] = (st[g] == ST_HITSTUN);
        assign alive[g]           = (st[g] == ST_ACTIVE) || (st[g] == ST_HITSTUN);
    end

    always_comb begin
        live_cnt  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (st[i] != ST_OUT) begin
                live_cnt  = live_cnt + 3'd1;
                win_idx   = 2'(i);
                win_found = 1'b1;
            end
        end
    end

    assign over_d = (live_cnt <= 3'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            game_over    <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
        end else begin
            game_over    <= over_d;
            winner       <= over_d ? win_idx : 2'd0;
            winner_valid <= over_d & win_found;
        end
    end

endmodule

// File: doc/combat_manager.md
COMBAT_MANAGER -- requirements
Module: combat_manager

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of players (legal 2..4).
REQ-002 SHALL have parameter DAMAGE_PER_HIT, default 12, damage points added per landed hit.
REQ-003 SHALL have parameter KO_THRESHOLD, default 100, damage at or above which a player is knocked out.
REQ-004 SHALL have parameter HITSTUN_FRAMES, default 20, frame ticks of hitstun after a hit.
REQ-005 SHALL have parameter STOCKS, default 3, lives per player (1..7).
REQ-006 SHALL have parameter RESPAWN_FRAMES, default 60, frame ticks spent in KO before respawn.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port reset_n, input, 1; one clock, reset asynchronous and active-low.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-010 SHALL have port attack_btn, input, NUM_PLAYERS, level attack button per player.
REQ-011 SHALL have port overlap, input, NUM_PLAYERS*NUM_PLAYERS, bit i*N+j = hitbox of i overlaps j.
REQ-012 SHALL have port damage, output, NUM_PLAYERS*10, packed per-player damage.
REQ-013 SHALL have port hit_stun_active, output, NUM_PLAYERS, player in HITSTUN.
REQ-014 SHALL have port alive, output, NUM_PLAYERS, player drawable (ACTIVE or HITSTUN).
REQ-015 SHALL have port stocks_left, output, NUM_PLAYERS*3, packed remaining lives.
REQ-016 SHALL have port respawn_pulse, output, NUM_PLAYERS, one-cycle pulse on respawn.
REQ-017 SHALL have ports game_over (1), winner (2), winner_valid (1), outputs.

Function
REQ-018 Each player SHALL run an FSM with states ACTIVE, HITSTUN, KO, OUT.
REQ-019 Attack edge for i SHALL be attack_btn[i] & ~prev_btn[i], prev_btn registered every cycle.
REQ-020 Attacker i SHALL hit victim j (j!=i) when edge i, attacker i in ACTIVE or HITSTUN=no (ACTIVE only), overlap[i*N+j]=1, victim j in ACTIVE.
REQ-021 A hit SHALL add DAMAGE_PER_HIT to damage[j] at the same clock edge the attack edge is sampled (1-cycle latency), saturating at 1023.
REQ-022 Multiple attackers hitting one victim in one cycle SHALL count as a single hit.
REQ-023 Mutual hits in one cycle SHALL both apply; both victims enter HITSTUN.
REQ-024 Hit with resulting damage < KO_THRESHOLD: victim -> HITSTUN, stun counter = HITSTUN_FRAMES.
REQ-025 HITSTUN SHALL decrement on frame_tick and return to ACTIVE on the tick that reaches 0; hits on a HITSTUN player are ignored.
REQ-026 Hit with resulting damage >= KO_THRESHOLD: stocks_left decrements; if result 0 -> OUT, else -> KO with counter RESPAWN_FRAMES.
REQ-027 KO SHALL count frame_ticks; on expiry damage clears to 0, respawn_pulse asserts one cycle, state -> ACTIVE.
REQ-028 OUT SHALL be terminal until reset; damage holds its last value.
REQ-029 game_over SHALL assert, registered, when at most one player is not OUT.
REQ-030 winner SHALL be lowest index not OUT; winner_valid=0 if all players OUT simultaneously.

Reset
REQ-031 On reset_n low: all states ACTIVE, damage 0, stocks_left STOCKS, counters 0, prev_btn 0, all pulses and game_over/winner/winner_valid 0.
REQ-032 Reset asserted mid-HITSTUN or mid-KO SHALL abort the counter immediately.
REQ-033 A button held through reset deassertion SHALL not produce an attack edge.

Configuration
REQ-034 With COMBAT_STUN_SCALE_EN defined, hitstun load SHALL be HITSTUN_FRAMES + (new damage >> 4).
REQ-035 Without COMBAT_STUN_SCALE_EN, hitstun load SHALL be HITSTUN_FRAMES exactly.

Structure
REQ-036 Package combat_pkg SHALL hold the player_state enum and width constants (DAMAGE_W=10, STOCK_W=3).
REQ-037 Per-player FSM SHALL be sub-module player_life_fsm, instantiated NUM_PLAYERS times via generate.

Verification
REQ-038 N=2, overlap[0*2+1]=1, P0 rising edge -> damage[1]=12 next cycle, hit_stun_active[1]=1 for 20 ticks.
REQ-039 P1 in HITSTUN, P0 presses again -> damage[1] stays 12.
REQ-040 N=3, P0 and P2 both hit P1 same cycle -> damage[1]=12, not 24.
REQ-041 Damage 96, hit -> stocks_left 2, alive 0, respawn_pulse after 60 ticks, damage 0.
REQ-042 STOCKS=1 N=2, KO P1 -> P1 OUT, game_over=1, winner=0, winner_valid=1.
REQ-043 reset_n low during KO -> all outputs at reset values, stocks_left=STOCKS.
